inst_rom: RTL and testbench

INST_ROM -- requirements
Module: inst_rom

---
 rtl/inst_rom_pkg.sv | 23 ++
 rtl/inst_rom_if.sv | 11 +
 rtl/inst_rom_rom_word_ram.sv | 23 ++
 rtl/inst_rom.sv | 117 +++++++++++
 tb/tb_inst_rom.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/inst_rom_pkg.sv
// rtl/inst_rom_pkg.sv - shared widths, NOP constant and FSM encoding for the instruction ROM
package inst_rom_pkg;

  localparam int INST_W      = 32;
  localparam int INST_ADDR_W = 32;

  typedef logic [INST_W-1:0]      InstBus;
  typedef logic [INST_ADDR_W-1:0] InstAddrBus;

  localparam InstBus NOP_INST = '0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } rom_state_e;

  // Bytes were shifted in from the LSB end, so a short word must be moved up to the MSB end.
  function automatic InstBus left_justify(input InstBus w, input logic [2:0] nbytes);
    return w << {3'd4 - nbytes, 3'b000};
  endfunction

endpackage

// File: rtl/inst_rom_if.sv
// rtl/inst_rom_if.sv - byte-stream program load handshake into the instruction ROM
interface inst_rom_if;
  logic       load_start;
  logic       load_valid;
  logic [7:0] load_byte;
  logic       load_ready;
  logic       load_end;

  modport master (output load_start, load_valid, load_byte, load_end, input load_ready);
  modport slave  (input load_start, load_valid, load_byte, load_end, output load_ready);
endinterface

// File: rtl/inst_rom_rom_word_ram.sv
// rtl/inst_rom_rom_word_ram.sv - word array with synchronous write and asynchronous read
module rom_word_ram
  import inst_rom_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  InstBus            wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output InstBus            rdata_o
);

  InstBus mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/inst_rom.sv
// rtl/inst_rom.sv - loadable instruction ROM with combinational fetch
module inst_rom
  import inst_rom_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ce,
  input  InstAddrBus          addr,
  output InstBus              inst_o,
  inst_rom_if.slave           load_if,
  output logic                busy,
  output logic                done,
  output logic                overflow,
  output logic [DEPTH_LOG2:0] word_count
);

  localparam logic [DEPTH_LOG2:0] PTR_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] ONE      = {{DEPTH_LOG2{1'b0}}, 1'b1};

  rom_state_e          state_q;
  logic [DEPTH_LOG2:0] ptr_q, wc_q;
  logic [1:0]          cnt_q;
  InstBus              asm_q;
  logic                busy_q, done_q, ovf_q, ready_q;

  logic                accept, full_word, partial, ptr_full, wr_en;
  logic [2:0]          eff_cnt;
  InstBus              eff_asm, wr_data, rdata;
  logic [DEPTH_LOG2:0] ptr_inc;

  always_comb begin
    ptr_full  = (ptr_q == PTR_FULL);
    accept    = (state_q == S_LOAD) && load_if.load_valid && ready_q;
    eff_asm   = accept ? {asm_q[23:0], load_if.load_byte} : asm_q;
    eff_cnt   = {1'b0, cnt_q} + {2'b00, accept};
    full_word = accept && (cnt_q == 2'd3);
    // A byte accepted alongside load_end is folded in before the tail word is finalised.
    partial   = (state_q == S_LOAD) && load_if.load_end && !full_word && (eff_cnt != 3'd0);
    wr_en     = (state_q == S_LOAD) && !load_if.load_start && (full_word || (partial && !ptr_full));
    wr_data   = full_word ? eff_asm : left_justify(eff_asm, eff_cnt);
    ptr_inc   = ptr_q + ONE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      wc_q    <= '0;
      cnt_q   <= '0;
      asm_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      ready_q <= 1'b0;
    end else if (load_if.load_start) begin
      state_q <= S_LOAD;
      ptr_q   <= '0;
      wc_q    <= '0;
      cnt_q   <= '0;
      asm_q   <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      ready_q <= 1'b1;
    end else if (state_q == S_LOAD) begin
      if (accept) begin
        asm_q <= eff_asm;
        cnt_q <= cnt_q + 2'd1;
      end
      if (full_word) begin
        ptr_q <= ptr_inc;
        wc_q  <= wc_q + ONE;
      end
      if (load_if.load_valid && !ready_q) ovf_q <= 1'b1;
      if (load_if.load_end) begin
        state_q <= S_DONE;
        busy_q  <= 1'b0;
        done_q  <= 1'b1;
        ready_q <= 1'b0;
        cnt_q   <= '0;
        asm_q   <= '0;
        if (partial) begin
          if (ptr_full) ovf_q <= 1'b1;
          else          wc_q  <= wc_q + ONE;
        end
      end else begin
        ready_q <= full_word ? (ptr_inc != PTR_FULL) : !ptr_full;
      end
    end
  end

  rom_word_ram #(.ADDR_W(DEPTH_LOG2)) u_ram (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (ptr_q[DEPTH_LOG2-1:0]),
    .wdata_i (wr_data),
    .raddr_i (addr[DEPTH_LOG2+1:2]),
    .rdata_o (rdata)
  );

  logic addr_hi;
  logic unused_addr;
  assign addr_hi     = |(addr >> (DEPTH_LOG2 + 2));
  assign unused_addr = ^addr[1:0];

  assign inst_o = (!ce || busy_q || addr_hi || ({1'b0, addr[DEPTH_LOG2+1:2]} >= wc_q))
                  ? NOP_INST : rdata;

  assign load_if.load_ready = ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign overflow   = ovf_q;
  assign word_count = wc_q;

endmodule

// File: tb/tb_inst_rom.sv
// tb/tb_inst_rom.sv - randomized self-checking bench for inst_rom at depths 1024 and 4
module tb_inst_rom;
  import inst_rom_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ce = 1'b0;
  logic [31:0] addr = '0;
  logic        drv_start = 1'b0, drv_valid = 1'b0, drv_end = 1'b0;
  logic [7:0]  drv_byte = '0;

  logic [31:0] inst_b, inst_s;
  logic        busy_b, done_b, ovf_b, busy_s, done_s, ovf_s;
  logic [10:0] wc_b;
  logic [2:0]  wc_s;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] sent[$];
  bit m_busy = 0;
  bit m_done = 0;

  inst_rom_if lf_b();
  inst_rom_if lf_s();

  assign lf_b.load_start = drv_start;
  assign lf_b.load_valid = drv_valid;
  assign lf_b.load_byte  = drv_byte;
  assign lf_b.load_end   = drv_end;
  assign lf_s.load_start = drv_start;
  assign lf_s.load_valid = drv_valid;
  assign lf_s.load_byte  = drv_byte;
  assign lf_s.load_end   = drv_end;

  inst_rom #(.DEPTH_LOG2(10)) dut_b (
    .clk(clk), .rst(rst), .ce(ce), .addr(addr), .inst_o(inst_b), .load_if(lf_b),
    .busy(busy_b), .done(done_b), .overflow(ovf_b), .word_count(wc_b)
  );

  inst_rom #(.DEPTH_LOG2(2)) dut_s (
    .clk(clk), .rst(rst), .ce(ce), .addr(addr), .inst_o(inst_s), .load_if(lf_s),
    .busy(busy_s), .done(done_s), .overflow(ovf_s), .word_count(wc_s)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: the image is the accepted byte list grouped big-endian into words, capped at depth.
  function automatic int accepted(input int dl);
    int cap = 4 << dl;
    return (sent.size() < cap) ? sent.size() : cap;
  endfunction

  function automatic int exp_wc(input int dl);
    return m_busy ? accepted(dl) / 4 : (accepted(dl) + 3) / 4;
  endfunction

  function automatic bit exp_ovf(input int dl);
    return sent.size() > (4 << dl);
  endfunction

  function automatic logic [31:0] exp_inst(input int dl, input logic c, input logic [31:0] a);
    logic [31:0] w;
    int idx, acc;
    if (!c || m_busy) return 32'h0;
    if ((a >> (dl + 2)) != 0) return 32'h0;
    idx = int'(a >> 2);
    if (idx >= exp_wc(dl)) return 32'h0;
    acc = accepted(dl);
    w = 32'h0;
    for (int k = 0; k < 4; k++)
      if (idx * 4 + k < acc) w |= 32'(sent[idx * 4 + k]) << (24 - 8 * k);
    return w;
  endfunction

  task automatic check_status(input string tag);
    check({tag, " busy_b"}, 64'(busy_b), 64'(m_busy));
    check({tag, " done_b"}, 64'(done_b), 64'(m_done));
    check({tag, " ovf_b"},  64'(ovf_b),  64'(exp_ovf(10)));
    check({tag, " wc_b"},   64'(wc_b),   64'(exp_wc(10)));
    check({tag, " busy_s"}, 64'(busy_s), 64'(m_busy));
    check({tag, " done_s"}, 64'(done_s), 64'(m_done));
    check({tag, " ovf_s"},  64'(ovf_s),  64'(exp_ovf(2)));
    check({tag, " wc_s"},   64'(wc_s),   64'(exp_wc(2)));
  endtask

  task automatic fetch(input string tag, input logic c, input logic [31:0] a);
    @(posedge clk);
    #1;
    ce = c;
    addr = a;
    #1;
    check($sformatf("%s inst_b @%0h", tag, a), 64'(inst_b), 64'(exp_inst(10, c, a)));
    check($sformatf("%s inst_s @%0h", tag, a), 64'(inst_s), 64'(exp_inst(2, c, a)));
  endtask

  task automatic do_start();
    drv_start = 1'b1;
    @(posedge clk);
    #1;
    drv_start = 1'b0;
    sent.delete();
    m_busy = 1;
    m_done = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit with_end);
    drv_valid = 1'b1;
    drv_byte  = b;
    drv_end   = with_end;
    @(posedge clk);
    #1;
    drv_valid = 1'b0;
    drv_end   = 1'b0;
    sent.push_back(b);
    if (with_end) begin
      m_busy = 0;
      m_done = 1;
    end
  endtask

  task automatic end_load();
    drv_end = 1'b1;
    @(posedge clk);
    #1;
    drv_end = 1'b0;
    m_busy = 0;
    m_done = 1;
  endtask

  initial begin
    logic [7:0] img0 [8] = '{8'h34, 8'h01, 8'h00, 8'h05, 8'h3C, 8'h02, 8'h12, 8'h34};
    logic [7:0] img1 [5] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};

    ce = 1'b1;
    #1;
    check_status("reset");
    check("reset ready_b", 64'(lf_b.load_ready), 64'(0));
    check("reset inst_b", 64'(inst_b), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    fetch("idle", 1'b1, 32'h0);

    do_start();
    foreach (img0[i]) send_byte(img0[i], 1'b0);
    end_load();
    check_status("img0");
    check("img0 word0", 64'(exp_inst(10, 1'b1, 32'h0)), 64'h34010005);
    fetch("img0", 1'b1, 32'h0);
    fetch("img0", 1'b1, 32'h4);
    fetch("img0", 1'b1, 32'h8);
    fetch("img0", 1'b1, 32'h6);
    fetch("img0 ce0", 1'b0, 32'h4);

    do_start();
    foreach (img1[i]) send_byte(img1[i], i == 4);
    check_status("img1");
    check("img1 word1", 64'(exp_inst(10, 1'b1, 32'h4)), 64'hEE000000);
    fetch("img1", 1'b1, 32'h4);
    fetch("img1", 1'b1, 32'h0);

    do_start();
    for (int i = 0; i < 16; i++) send_byte(8'($urandom), 1'b0);
    check("full ready_s", 64'(lf_s.load_ready), 64'(0));
    check("full ready_b", 64'(lf_b.load_ready), 64'(1));
    check("full ovf_s pre", 64'(ovf_s), 64'(0));
    send_byte(8'h5A, 1'b0);
    check_status("full17");
    end_load();
    check_status("full end");
    check("full ready_s done", 64'(lf_s.load_ready), 64'(0));
    fetch("full", 1'b1, 32'hC);
    fetch("full", 1'b1, 32'h10);

    do_start();
    for (int i = 0; i < 12; i++) send_byte(8'($urandom), 1'b0);
    check_status("mid");
    fetch("mid busy", 1'b1, 32'h0);
    rst = 1'b0;
    sent.delete();
    m_busy = 0;
    m_done = 0;
    #1;
    check_status("rst mid");
    check("rst mid inst_b", 64'(inst_b), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b1;
    fetch("after rst", 1'b1, 32'h0);

    do_start();
    for (int i = 0; i < 9; i++) send_byte(8'($urandom), 1'b0);
    check_status("pre restart");
    do_start();
    check_status("restart");
    send_byte(8'h11, 1'b1);
    check_status("restart end");
    fetch("restart", 1'b1, 32'h0);

    for (int it = 0; it < 40; it++) begin
      int n;
      bit same;
      n = $urandom_range(0, 20);
      same = ($urandom_range(0, 1) == 1) && (n > 0);
      do_start();
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk);
          #1;
        end
        send_byte(8'($urandom), same && (i == n - 1));
      end
      if (!same) end_load();
      check_status($sformatf("rand%0d", it));
      for (int f = 0; f < 4; f++) begin
        logic [31:0] a;
        a = ($urandom_range(0, 5) == 0) ? $urandom : 32'($urandom_range(0, 27));
        fetch($sformatf("rand%0d", it), $urandom_range(0, 7) != 0, a);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
